// File: rtl/xmtfifo.sv
// Serial-line transmitter with integrated FIFO: start bit, LSB-first data, optional parity, stop bits.
// Define XMTFIFO_PARITY_EN to add one parity bit per frame (odd when PARITY_ODD=1, else even).
module xmtfifo #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write,
  output logic                     ready,
  input  logic [DATA_BITS-1:0]     data_in,
  output logic                     serial_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef XMTFIFO_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
`ifdef XMTFIFO_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 empty, full, push, pop, last_tick, start_frame;
  logic [DATA_BITS-1:0] head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level      = wr_ptr_q - rd_ptr_q;
  assign ready      = !full;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign serial_out = serial_q;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = write && !full;
  assign last_tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == S_IDLE) ? '0 : (last_tick ? '0 : cnt_q + CW'(1));
    bit_d       = bit_q;
    shift_d     = shift_q;
    serial_d    = serial_q;
    start_frame = 1'b0;
    pop         = 1'b0;
`ifdef XMTFIFO_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        serial_d    = 1'b1;
        start_frame = !empty;
      end
      S_START: if (last_tick) begin
        state_d  = S_DATA;
        bit_d    = '0;
        serial_d = shift_q[0];
      end
      S_DATA: if (last_tick) begin
        if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef XMTFIFO_PARITY_EN
          state_d  = S_PARITY;
          serial_d = parity_q;
`else
          state_d  = S_STOP;
          serial_d = 1'b1;
          bit_d    = '0;
`endif
        end else begin
          bit_d    = bit_q + BW'(1);
          shift_d  = shift_q >> 1;
          serial_d = shift_q[1];
        end
      end
`ifdef XMTFIFO_PARITY_EN
      S_PARITY: if (last_tick) begin
        state_d  = S_STOP;
        serial_d = 1'b1;
        bit_d    = '0;
      end
`endif
      S_STOP: if (last_tick) begin
        if (bit_q == BW'(STOP_BITS - 1)) begin
          // Chain straight into the next start bit when more words are waiting.
          if (!empty) start_frame = 1'b1;
          else        state_d     = S_IDLE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase
    if (start_frame) begin
      pop      = 1'b1;
      shift_d  = head;
      serial_d = 1'b0;
      state_d  = S_START;
      cnt_d    = '0;
`ifdef XMTFIFO_PARITY_EN
      parity_d = (^head) ^ (PARITY_ODD != 0);
`endif
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
`ifdef XMTFIFO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef XMTFIFO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_xmtfifo.sv
// Bench for xmtfifo: queue/bit-list reference model compared every cycle plus literal frame checks.
module tb_xmtfifo;
  localparam int DB = 8, DEPTH = 4, CPB = 4, STOPB = 1, PODD = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, serial_out, busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  xmtfifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .ready(ready), .data_in(data_in),
    .serial_out(serial_out), .level(level), .busy(busy));

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, the frame on the wire as a per-cycle list of line values.
  logic [7:0] mq[$];
  logic       fr[$];
  logic       m_line = 1'b1;
  logic       m_active = 1'b0;

  task automatic add_bit(input logic b);
    repeat (CPB) fr.push_back(b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    int pre;
    logic [7:0] w;
    if (!reset_n) begin
      mq.delete();
      fr.delete();
      m_line   = 1'b1;
      m_active = 1'b0;
    end else begin
      pre = mq.size();
      if (fr.size() == 0) begin
        if (pre > 0) begin
          w = mq.pop_front();
          add_bit(1'b0);
          for (int i = 0; i < DB; i++) add_bit(w[i]);
`ifdef XMTFIFO_PARITY_EN
          add_bit((^w) ^ (PODD != 0));
`endif
          for (int s = 0; s < STOPB; s++) add_bit(1'b1);
          m_line   = fr.pop_front();
          m_active = 1'b1;
        end else begin
          m_line   = 1'b1;
          m_active = 1'b0;
        end
      end else begin
        m_line = fr.pop_front();
      end
      if (write && pre < DEPTH) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("model_serial", serial_out, m_line);
      chk("model_level", level, mq.size());
      chk("model_ready", ready, mq.size() != DEPTH);
      chk("model_busy", busy, m_active || mq.size() != 0);
    end
  end

  // Called at a negedge; the write lands on the following rising edge.
  task automatic put(input logic [7:0] d);
    write = 1'b1;
    data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Sends one word from idle and checks the line bit by bit against a literal pattern.
  task automatic check_frame(input string name, input logic [7:0] d, input logic [10:0] exp_bits, input int nbits);
    put(d);
    chk({name, "_latency_line"}, serial_out, 1'b1);
    chk({name, "_latency_level"}, level, 1);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      chk({name, "_bit"}, serial_out, exp_bits[i / CPB]);
    end
    @(negedge clk);
    chk({name, "_busy_end"}, busy, 1'b0);
    chk({name, "_line_end"}, serial_out, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Asynchronous reset with no clock edge in between
    #2 reset_n = 1'b0;
    #1;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single frame with a literal line pattern
`ifdef XMTFIFO_PARITY_EN
    check_frame("a5", 8'hA5, 11'b10101001010, 11);
    check_frame("p07", 8'h07, 11'b11000001110, 11);
    check_frame("p03", 8'h03, 11'b10000000110, 11);
`else
    check_frame("a5", 8'hA5, 11'b01101001010, 10);
    check_frame("n07", 8'h07, 11'b01000001110, 10);
`endif

    // Burst: FIFO fills to DEPTH, the extra write is dropped
    for (int i = 1; i <= 5; i++) put(8'(i));
    chk("burst_level_peak", level, 4);
    chk("burst_ready_full", ready, 1'b0);
    put(8'h06);
    chk("burst_drop_level", level, 4);
    wait_idle(400);

    // Push and pop on the same edge at level 2
    put(8'h11);
    put(8'h22);
    put(8'h33);
    chk("pp_level_pre", level, 2);
    n = 0;
    while (!(m_active && fr.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pp_wait_timeout", n < 200, 1'b1);
    put(8'h44);
    chk("pp_level_post", level, 2);
    wait_idle(400);

    // Reset in the middle of a data bit with words queued
    put(8'hFF);
    put(8'hA1);
    put(8'hA2);
    put(8'hA3);
    chk("r5_level_pre", level, 3);
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("r5_serial", serial_out, 1'b1);
    chk("r5_level", level, 0);
    chk("r5_ready", ready, 1'b1);
    chk("r5_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      chk("r5_quiet_line", serial_out, 1'b1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      write = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      @(negedge clk);
    end
    write = 1'b0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
